ysyx_040066_mem_responder: RTL and testbench
============================================

YSYX_040066_MEM_RESPONDER -- requirements
Module: ysyx_040066_mem_responder

Interface
REQ-001 SHALL have parameters: BASE, default 64'h8000_0000, byte address of word 0; AW, default 16, log2 of memory depth in 64-bit words; LATENCY, default 4, extra wait cycles before the first beat (used only under REQ-024).
REQ-002 SHALL have ports: clk  in  1  single clock; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ins_req in 1; ins_burst in 1; ins_addr in 64; ins_ready out 1; ins_err out 1; ins_last out 1; ins_data out 64; forming the instruction-fetch read port.
REQ-004 SHALL have ports: rd_req in 1; rd_burst in 1; rd_len in 3, log2 of access bytes; rd_addr in 64; rd_ready out 1; rd_err out 1; rd_last out 1; rd_data out 64; forming the data read port.
REQ-005 SHALL have ports: wr_req in 1; wr_burst in 1; wr_len in 3; wr_mask in 8, byte enables for single writes; wr_addr in 64; wr_data in 512, line data, word i in bits [64i+63:64i]; wr_ready out 1; wr_err out 1; forming the data write port.

Function
REQ-006 SHALL hold 2^AW 64-bit words; word index = (addr-BASE)>>3.
REQ-007 SHALL use FSM states IDLE, WAIT, RBEAT, WBEAT, DONE, serving one transaction at a time.
REQ-008 In IDLE, on any req high, SHALL accept exactly one, with priority wr > rd > ins, and latch port, burst flag, addr, len, mask, wr_data.
REQ-009 Requests SHALL be sampled only in IDLE; req of an unaccepted port SHALL be ignored until the next IDLE.
REQ-010 Burst SHALL force addr[5:0]=0 and transfer 8 words, index base+0..base+7.
REQ-011 Read burst: accept at cycle T -> ready=1 in T+1..T+8 with data word i at T+1+i; last=1 only at T+8.
REQ-012 Single read: ready=1 and last=1 at T+1; data = full aligned 64-bit word; ins port is always treated as 8-byte access.
REQ-013 Single write: bytes where wr_mask[b]=1 updated at the T+1 edge; wr_ready=1 at T+1.
REQ-014 Burst write: word i written in cycle T+1+i, all 8 bytes; wr_ready=1 only at T+8.
REQ-015 Error: address outside [BASE, BASE+2^(AW+3)) or single access with addr[len-1:0]!=0 or len>3 -> no memory access; ready=1, err=1 (and last=1 for read ports) in a single cycle at T+1; burst is terminated.
REQ-016 err SHALL be 0 whenever ready is 0.
REQ-017 After the final ready cycle the FSM SHALL enter DONE for exactly one cycle, ignoring all requests, then IDLE; back-to-back accepts SHALL be separated by two cycles.
REQ-018 ready/last/err/data SHALL be asserted only on the port being served; other ports' outputs SHALL be 0.
REQ-019 Data outputs SHALL be registered; rd_data/ins_data SHALL be 0 when the respective ready is 0.
REQ-020 Beat counter SHALL be 3 bits and wrap is impossible (transaction ends at count 7).

Reset
REQ-021 rst high at a clock edge SHALL force state IDLE, counter 0, all ready/last/err/data outputs 0 in the following cycle.
REQ-022 Reset mid-transaction SHALL abandon it; words already written in a burst SHALL remain written; memory contents SHALL NOT be cleared.
REQ-023 First request SHALL be accepted in the first cycle after rst deasserts.

Configuration
REQ-024 Macro YSYX_040066_MEM_LATENCY_EN defined: accept goes IDLE->WAIT for LATENCY cycles, shifting all response timings in REQ-011..REQ-015 by LATENCY; undefined: WAIT state absent, timings exactly as stated.

Verification
REQ-025 Reset, then wr_req single, addr 0x8000_0008, mask 8'h0F, data 0x1122334455667788 -> wr_ready at T+1; following rd single 0x8000_0008 returns 0x0000000055667788 at T+1 with last=1.
REQ-026 wr burst at 0x8000_0040, words 0..7 = 0x100..0x107, then ins burst at 0x8000_0050 -> ins_ready T+1..T+8, data 0x100..0x107, ins_last only at T+8.
REQ-027 wr_req, rd_req and ins_req raised in the same cycle -> write served first, then rd, then ins, each accept two cycles after the previous final ready.
REQ-028 rd single, len=2, addr 0x8000_0002 -> rd_ready=rd_err=rd_last=1 at T+1; rd burst at 0x7FFF_FFC0 -> single error beat; memory unchanged.
REQ-029 rst pulsed at T+3 of a write burst -> outputs 0 next cycle; words 0..1 updated, words 2..7 unchanged.
REQ-030 With YSYX_040066_MEM_LATENCY_EN and LATENCY=4, single rd -> rd_ready at T+5.

Source files
------------

// File: rtl/ysyx_040066_mem_responder.sv
// ysyx_040066_mem_responder: three-port (ins read / data read / data write)
// 64-bit word memory model serving one transaction at a time.
// Optional macro YSYX_040066_MEM_LATENCY_EN inserts a WAIT state of LATENCY
// cycles between accept and the first response beat.
module ysyx_040066_mem_responder #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          AW      = 16,
  parameter int          LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_req,
  input  logic         ins_burst,
  input  logic [63:0]  ins_addr,
  output logic         ins_ready,
  output logic         ins_err,
  output logic         ins_last,
  output logic [63:0]  ins_data,
  input  logic         rd_req,
  input  logic         rd_burst,
  input  logic [2:0]   rd_len,
  input  logic [63:0]  rd_addr,
  output logic         rd_ready,
  output logic         rd_err,
  output logic         rd_last,
  output logic [63:0]  rd_data,
  input  logic         wr_req,
  input  logic         wr_burst,
  input  logic [2:0]   wr_len,
  input  logic [7:0]   wr_mask,
  input  logic [63:0]  wr_addr,
  input  logic [511:0] wr_data,
  output logic         wr_ready,
  output logic         wr_err
);

  localparam logic [1:0] P_INS = 2'd0;
  localparam logic [1:0] P_RD  = 2'd1;
  localparam logic [1:0] P_WR  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef YSYX_040066_MEM_LATENCY_EN
    S_WAIT  = 3'd1,
`endif
    S_RBEAT = 3'd2,
    S_WBEAT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

`ifdef YSYX_040066_MEM_LATENCY_EN
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  logic [WCW-1:0] wcnt_q, wcnt_d;
`endif

  logic [63:0] mem_q [2**AW];

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [1:0]      port_q, port_d;
  logic            burst_q, burst_d;
  logic            err_q, err_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [7:0]      mask_q, mask_d;
  logic [511:0]    wdata_q, wdata_d;

  logic            ins_ready_q, ins_ready_d, ins_err_q, ins_err_d, ins_last_q, ins_last_d;
  logic            rd_ready_q, rd_ready_d, rd_err_q, rd_err_d, rd_last_q, rd_last_d;
  logic            wr_ready_q, wr_ready_d, wr_err_q, wr_err_d;
  logic [63:0]     ins_data_q, ins_data_d, rd_data_q, rd_data_d;

  // arbitration and request decode (wr > rd > ins)
  logic            acc_any, sel_burst, sel_err;
  logic [1:0]      sel_port;
  logic [2:0]      sel_len;
  logic [63:0]     sel_addr, eff_addr, off;
  logic [AW-1:0]   sel_idx;

  // pick the winning port and check range / alignment of its address
  always_comb begin
    acc_any   = wr_req | rd_req | ins_req;
    sel_port  = P_INS;
    sel_burst = ins_burst;
    sel_len   = 3'd3;
    sel_addr  = ins_addr;
    if (wr_req) begin
      sel_port  = P_WR;
      sel_burst = wr_burst;
      sel_len   = wr_len;
      sel_addr  = wr_addr;
    end else if (rd_req) begin
      sel_port  = P_RD;
      sel_burst = rd_burst;
      sel_len   = rd_len;
      sel_addr  = rd_addr;
    end
    eff_addr = sel_burst ? {sel_addr[63:6], 6'b0} : sel_addr;
    off      = eff_addr - BASE;
    sel_idx  = off[AW+2:3];
    sel_err  = (eff_addr < BASE) || ((off >> (AW + 3)) != 64'd0);
    if (!sel_burst)
      sel_err = sel_err || (sel_len > 3'd3) ||
                ((eff_addr & ((64'd1 << sel_len) - 64'd1)) != 64'd0);
  end

  // state and transaction context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      port_q  <= P_INS;
      burst_q <= 1'b0;
      err_q   <= 1'b0;
      widx_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
`ifdef YSYX_040066_MEM_LATENCY_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      widx_q  <= widx_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
`ifdef YSYX_040066_MEM_LATENCY_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  // next state: accept in IDLE, count beats, one DONE cycle between transactions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    burst_d = burst_q;
    err_d   = err_q;
    widx_d  = widx_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
`ifdef YSYX_040066_MEM_LATENCY_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      S_IDLE: if (acc_any) begin
        port_d  = sel_port;
        burst_d = sel_burst;
        err_d   = sel_err;
        widx_d  = sel_idx;
        mask_d  = wr_mask;
        wdata_d = wr_data;
        cnt_d   = 3'd0;
`ifdef YSYX_040066_MEM_LATENCY_EN
        wcnt_d  = '0;
        state_d = S_WAIT;
`else
        state_d = (sel_port == P_WR) ? S_WBEAT : S_RBEAT;
`endif
      end
`ifdef YSYX_040066_MEM_LATENCY_EN
      S_WAIT: begin
        if (wcnt_q == WCW'(LATENCY - 1))
          state_d = (port_q == P_WR) ? S_WBEAT : S_RBEAT;
        else
          wcnt_d = wcnt_q + 1'b1;
      end
`endif
      S_RBEAT, S_WBEAT: begin
        // errors and singles finish after one beat, bursts at count 7
        if (err_q || !burst_q || cnt_q == 3'd7) state_d = S_DONE;
        else                                     cnt_d   = cnt_q + 3'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // response values for the coming cycle, registered below
  logic        beat_d, fin_d, rd_side_d, rdy_d;
  logic [63:0] rword, dat_d;

  always_comb begin
    beat_d    = (state_d == S_RBEAT) || (state_d == S_WBEAT);
    fin_d     = err_d || !burst_d || (cnt_d == 3'd7);
    rd_side_d = (port_d != P_WR);
    rdy_d     = beat_d && (rd_side_d || fin_d);
    rword     = mem_q[widx_d + AW'(cnt_d)];
    dat_d     = (beat_d && rd_side_d && !err_d) ? rword : 64'd0;
    ins_ready_d = rdy_d && (port_d == P_INS);
    ins_err_d   = ins_ready_d && err_d;
    ins_last_d  = ins_ready_d && fin_d;
    ins_data_d  = (port_d == P_INS) ? dat_d : 64'd0;
    rd_ready_d  = rdy_d && (port_d == P_RD);
    rd_err_d    = rd_ready_d && err_d;
    rd_last_d   = rd_ready_d && fin_d;
    rd_data_d   = (port_d == P_RD) ? dat_d : 64'd0;
    wr_ready_d  = rdy_d && (port_d == P_WR);
    wr_err_d    = wr_ready_d && err_d;
  end

  // registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      {ins_ready_q, ins_err_q, ins_last_q} <= 3'b0;
      {rd_ready_q, rd_err_q, rd_last_q}    <= 3'b0;
      {wr_ready_q, wr_err_q}               <= 2'b0;
      ins_data_q <= 64'd0;
      rd_data_q  <= 64'd0;
    end else begin
      {ins_ready_q, ins_err_q, ins_last_q} <= {ins_ready_d, ins_err_d, ins_last_d};
      {rd_ready_q, rd_err_q, rd_last_q}    <= {rd_ready_d, rd_err_d, rd_last_d};
      {wr_ready_q, wr_err_q}               <= {wr_ready_d, wr_err_d};
      ins_data_q <= ins_data_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign ins_ready = ins_ready_q;
  assign ins_err   = ins_err_q;
  assign ins_last  = ins_last_q;
  assign ins_data  = ins_data_q;
  assign rd_ready  = rd_ready_q;
  assign rd_err    = rd_err_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign wr_ready  = wr_ready_q;
  assign wr_err    = wr_err_q;

  // write beat: one word per WBEAT cycle, committed at the end of that cycle
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [63:0]   mem_wword;
  logic [7:0]    mem_be;

  always_comb begin
    mem_we    = (state_q == S_WBEAT) && !err_q;
    mem_widx  = widx_q + AW'(cnt_q);
    mem_wword = burst_q ? wdata_q[{cnt_q, 6'b0} +: 64] : wdata_q[63:0];
    mem_be    = burst_q ? 8'hFF : mask_q;
  end

  // memory array is never reset; a reset edge blocks the pending write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < 8; b++)
        if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wword[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ysyx_040066_mem_responder.sv
// Randomized bench for ysyx_040066_mem_responder against a word-array model.
module tb_ysyx_040066_mem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          AW   = 16;
  localparam logic [63:0] MEMB = 64'd1 << (AW + 3);
`ifdef YSYX_040066_MEM_LATENCY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0, rst;
  logic         ins_req, ins_burst, ins_ready, ins_err, ins_last;
  logic [63:0]  ins_addr, ins_data;
  logic         rd_req, rd_burst, rd_ready, rd_err, rd_last;
  logic [2:0]   rd_len;
  logic [63:0]  rd_addr, rd_data;
  logic         wr_req, wr_burst, wr_ready, wr_err;
  logic [2:0]   wr_len;
  logic [7:0]   wr_mask;
  logic [63:0]  wr_addr;
  logic [511:0] wr_data;

  ysyx_040066_mem_responder dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
    .ins_ready(ins_ready), .ins_err(ins_err), .ins_last(ins_last), .ins_data(ins_data),
    .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
    .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [63:0] mdl [int];   // word index -> contents

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] ctl();
    return {ins_ready, ins_err, ins_last, rd_ready, rd_err, rd_last, wr_ready, wr_err};
  endfunction

  task automatic clr_req();
    ins_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
  endtask

  // Issue one transaction from an IDLE cycle (called at a negedge) and check
  // every response cycle plus the DONE cycle; returns at the next IDLE negedge.
  task automatic do_txn(input string tag, input int port, input bit burst, input logic [2:0] len,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [511:0] wd);
    logic [63:0] ea, ed, w;
    logic [7:0]  ec;
    bit          err, fin;
    int          elen, nb, w0;
    ea   = burst ? (addr & ~64'h3F) : addr;
    elen = (port == 0) ? 3 : int'(len);
    err  = (ea < BASE) || (ea >= BASE + MEMB) ||
           (!burst && (elen > 3 || (ea % (64'd1 << elen)) != 64'd0));
    w0   = err ? 0 : int'((ea - BASE) / 8);
    nb   = (err || !burst) ? 1 : 8;
    case (port)
      0: begin ins_req = 1; ins_burst = burst; ins_addr = addr; end
      1: begin rd_req = 1; rd_burst = burst; rd_len = len; rd_addr = addr; end
      default: begin wr_req = 1; wr_burst = burst; wr_len = len; wr_addr = addr;
                     wr_mask = mask; wr_data = wd; end
    endcase
    @(posedge clk);
    @(negedge clk);
    clr_req();
    repeat (LAT) @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      fin = (b == nb - 1);
      ed  = (port != 2 && !err) ? mdl[w0 + b] : 64'd0;
      case (port)
        0:       ec = {1'b1, err, fin, 5'b0};
        1:       ec = {3'b0, 1'b1, err, fin, 2'b0};
        default: ec = {6'b0, fin, err && fin};
      endcase
      chk($sformatf("%s.b%0d.ctl", tag, b), {56'd0, ctl()}, {56'd0, ec});
      chk($sformatf("%s.b%0d.ins_data", tag, b), ins_data, (port == 0) ? ed : 64'd0);
      chk($sformatf("%s.b%0d.rd_data", tag, b), rd_data, (port == 1) ? ed : 64'd0);
      @(negedge clk);
    end
    chk($sformatf("%s.done.ctl", tag), {56'd0, ctl()}, 64'd0);
    chk($sformatf("%s.done.data", tag), ins_data | rd_data, 64'd0);
    if (port == 2 && !err) begin
      if (burst) for (int i = 0; i < 8; i++) mdl[w0 + i] = wd[64*i +: 64];
      else begin
        w = mdl.exists(w0) ? mdl[w0] : 64'd0;
        for (int i = 0; i < 8; i++) if (mask[i]) w[8*i +: 8] = wd[8*i +: 8];
        mdl[w0] = w;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] wd;
    logic [63:0]  a, wv, rdv, insv;
    int           port, cw, cr, ci;
    bit           bst;
    logic [2:0]   ln;
    clr_req();
    {ins_burst, rd_burst, wr_burst} = '0;
    {ins_addr, rd_addr, wr_addr} = '0;
    {rd_len, wr_len, wr_mask} = '0;
    wr_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ctl", {56'd0, ctl()}, 64'd0);
    chk("reset.data", ins_data | rd_data, 64'd0);
    rst = 1'b0;

    // first request goes in the cycle right after reset release
    do_txn("zero_line0", 2, 1, 3'd3, BASE, 8'hFF, '0);
    do_txn("w25", 2, 0, 3'd3, BASE + 64'h8, 8'h0F, {448'd0, 64'h1122_3344_5566_7788});
    do_txn("r25", 1, 0, 3'd3, BASE + 64'h8, 8'h00, '0);
    chk("r25.model", mdl[1], 64'h0000_0000_5566_7788);

    wd = '0;
    for (int i = 0; i < 8; i++) wd[64*i +: 64] = 64'h100 + 64'(i);
    do_txn("w26", 2, 1, 3'd3, BASE + 64'h40, 8'h00, wd);
    do_txn("i26", 0, 1, 3'd3, BASE + 64'h50, 8'h00, '0);

    for (int l = 2; l < 16; l++) do_txn($sformatf("init%0d", l), 2, 1, 3'd3, BASE + 64'(l*64), 8'h00, rnd_line());

    for (int n = 0; n < 120; n++) begin
      port = $urandom_range(2);
      bst  = $urandom_range(1);
      ln   = 3'($urandom_range(3));
      if (bst) a = BASE + 64'($urandom_range(15) * 64 + $urandom_range(63));
      else     a = BASE + 64'($urandom_range(127) * 8) + 64'(($urandom % (8 >> ln)) << ln);
      case ($urandom_range(11))
        0: a = BASE - 64'(8 * (1 + $urandom_range(3)));
        1: a = BASE + MEMB + 64'($urandom_range(127) * 8);
        2: ln = 3'(4 + $urandom_range(3));
        3: a = a | 64'd1;
        default: ;
      endcase
      do_txn($sformatf("rnd%0d", n), port, bst, ln, a, 8'($urandom), rnd_line());
    end

    do_txn("e_misal", 1, 0, 3'd2, BASE + 64'h2, 8'h00, '0);
    do_txn("e_below", 1, 1, 3'd3, 64'h7FFF_FFC0, 8'h00, '0);
    do_txn("e_above", 2, 0, 3'd3, BASE + MEMB, 8'hFF, rnd_line());
    do_txn("e_len", 2, 0, 3'd4, BASE + 64'h10, 8'hFF, rnd_line());
    do_txn("e_ins", 0, 0, 3'd3, BASE + 64'h4, 8'h00, '0);
    do_txn("e_wburst", 2, 1, 3'd3, BASE - 64'h40, 8'h00, rnd_line());
    do_txn("e_chk0", 1, 1, 3'd3, BASE, 8'h00, '0);

    // all three ports requesting together
    wv = {$urandom, $urandom};
    wr_req = 1; wr_burst = 0; wr_len = 3; wr_mask = 8'hFF; wr_addr = BASE + 64'(40*8);
    wr_data = {448'd0, wv};
    rd_req = 1; rd_burst = 0; rd_len = 3; rd_addr = BASE + 64'(40*8);
    ins_req = 1; ins_burst = 0; ins_addr = BASE + 64'(50*8);
    cw = -1; cr = -1; ci = -1; rdv = '0; insv = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (wr_ready && cw < 0) begin cw = k; wr_req = 0; end
      if (rd_ready && cr < 0) begin cr = k; rd_req = 0; rdv = rd_data; end
      if (ins_ready && ci < 0) begin ci = k; ins_req = 0; insv = ins_data; end
    end
    clr_req();
    mdl[40] = wv;
    chk("b2b.wr_cycle", 64'(cw), 64'(1 + LAT));
    chk("b2b.rd_cycle", 64'(cr), 64'(4 + 2*LAT));
    chk("b2b.ins_cycle", 64'(ci), 64'(7 + 3*LAT));
    chk("b2b.rd_data", rdv, wv);
    chk("b2b.ins_data", insv, mdl[50]);

    // reset in the third response cycle of a write burst
    wd = rnd_line();
    wr_req = 1; wr_burst = 1; wr_len = 3; wr_addr = BASE + 64'(6*64); wr_data = wd;
    @(posedge clk);
    @(negedge clk);
    clr_req();
    repeat (2 + LAT) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid.ctl", {56'd0, ctl()}, 64'd0);
    chk("rst_mid.data", ins_data | rd_data, 64'd0);
    rst = 1'b0;
    mdl[48] = wd[63:0];
    mdl[49] = wd[127:64];
    do_txn("rst_mid.rd", 1, 1, 3'd3, BASE + 64'(6*64), 8'h00, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
